ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the operand and result width (legal values 8..64, even).
REQ-002 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have the port start, input, 1 bit: request a new operation; sampled only when busy is low.
REQ-005 The module SHALL have the port op, input, 3 bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The module SHALL have the ports srca and srcb, input, XLEN bits each: operands, captured on start acceptance.
REQ-007 The module SHALL have the port flush, input, 1 bit: synchronous abort of any operation in progress.
REQ-008 The module SHALL have the port busy, output, 1 bit: the unit holds an operation; the EX stage stalls while it is high.
REQ-009 The module SHALL have the port done, output, 1 bit: a one-cycle pulse marking result valid.
REQ-010 The module SHALL have the port result, output, XLEN bits: the registered result, held until the next done.

Function
REQ-011 The FSM SHALL have states IDLE, CALC, FIX and DONE; busy SHALL be high exactly in CALC and FIX; done SHALL be high exactly in DONE.
REQ-012 start SHALL be accepted in IDLE or DONE when flush is low; at acceptance, op and the operands SHALL be registered, together with their magnitudes and result-sign flags per op signedness.
REQ-013 A normal op SHALL go IDLE/DONE -> CALC with the iteration counter at XLEN-1, and SHALL run one shift-add (mul) or restoring-subtract (div) step per cycle.
REQ-014 The FSM SHALL move CALC -> FIX when the counter reaches 0 (XLEN CALC cycles), and FIX SHALL apply two's-complement sign correction and select the high/low product half, quotient or remainder.
REQ-015 FIX -> DONE SHALL load result; done SHALL therefore assert exactly XLEN+2 cycles after the acceptance cycle (34 for XLEN=32).
REQ-016 Multiplication SHALL form the 2*XLEN-bit product: MUL returns the low half; MULH, MULHSU and MULHU return the high half with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-017 Division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-018 Division by zero SHALL skip CALC and go directly to DONE, with quotient = all ones and remainder = srca; done SHALL assert 1 cycle after acceptance.
REQ-019 Signed overflow (DIV/REM of the most-negative value by -1) SHALL skip CALC and go directly to DONE, with quotient = most-negative value and remainder = 0; done SHALL assert 1 cycle after acceptance.
REQ-020 From DONE without an accepted start, the FSM SHALL return to IDLE; a start in DONE SHALL begin the next op back-to-back with no idle cycle.
REQ-021 start while busy is high SHALL be ignored, with no effect on state or operands.
REQ-022 flush SHALL force IDLE at the next edge from any state, suppress done, and leave result unchanged.
REQ-023 flush and start asserted in the same cycle SHALL cause flush to win, and the start SHALL be dropped.
REQ-024 op and the operands SHALL be ignored outside acceptance; changes during CALC SHALL not affect the result.

Reset
REQ-025 While rst_n is low, the FSM SHALL be in IDLE, with busy=0, done=0, result=0, and the counter and internal accumulators at 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL abandon the op without asserting done; the first start after deassertion SHALL be accepted normally.
REQ-027 rst_n deassertion SHALL be used only as a synchronised release; no state changes SHALL occur on the deasserting edge other than leaving reset.

Verification
REQ-028 MUL srca=7, srcb=0xFFFFFFFD -> result=0xFFFFFFEB, done at cycle 34, busy high for cycles 1..33.
REQ-029 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, done at cycle 1; REM same operands -> 0.
REQ-031 DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each with done at cycle 1; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
REQ-032 flush at cycle 10 of a DIV -> busy=0 at cycle 11, no done pulse, prior result retained; start at cycle 11 completes normally.
REQ-033 Back-to-back: a start held high in the DONE cycle -> second done exactly 34 cycles later; rst_n pulsed low mid-CALC -> outputs 0 immediately.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiply and restoring divide,
// one bit per cycle, with a fast path for divide-by-zero and signed overflow.
module ex_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] b_mag_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic            neg_q;
  logic            neg_r;

  // Operand decode at acceptance: signedness, magnitudes and fast-path detection
  logic            in_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, quick_res;

  always_comb begin
    in_div   = op[2];
    a_signed = in_div ? ~op[0] : (op[1:0] != 2'b11);
    b_signed = in_div ? ~op[0] : ~op[1];
    a_neg    = a_signed & srca[XLEN-1];
    b_neg    = b_signed & srcb[XLEN-1];
    a_mag    = a_neg ? (~srca + XLEN'(1)) : srca;
    b_mag    = b_neg ? (~srcb + XLEN'(1)) : srcb;
    div_zero = in_div & (srcb == '0);
    div_ovf  = in_div & ~op[0] & (srca == MIN_NEG) & (srcb == '1);
    if (div_zero)
      quick_res = op[1] ? srca : '1;
    else
      quick_res = op[1] ? '0 : MIN_NEG;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  logic [XLEN:0]   mul_sum, mul_s, div_sh, div_diff;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, b_mag_q};
    mul_s    = lo_q[0] ? mul_sum : {1'b0, hi_q};
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_mag_q};
    if (!op_q[2]) begin
      step_hi = mul_s[XLEN:1];
      step_lo = {mul_s[0], lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      step_hi = div_diff[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      step_hi = div_sh[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and half/quotient/remainder select
  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fix_res;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? (~prod + PW'(1)) : prod;
    quo_s  = neg_q ? (~lo_q + XLEN'(1)) : lo_q;
    rem_s  = neg_r ? (~hi_q + XLEN'(1)) : hi_q;
    if (!op_q[2])
      fix_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
    else
      fix_res = op_q[1] ? rem_s : quo_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      b_mag_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q    <= op;
            b_mag_q <= b_mag;
            hi_q    <= '0;
            lo_q    <= a_mag;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            if (div_zero || div_ovf) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= quick_res;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              done  <= 1'b0;
              cnt   <= CW'(XLEN - 1);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        CALC: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          cnt  <= cnt - CW'(1);
          if (cnt == '0)
            state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected results queued at issue, popped at done.
module tb_ex_muldiv;

  localparam int unsigned XLEN = 32;
  localparam int NORM_LAT = XLEN + 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] srca = '0;
  logic [XLEN-1:0] srcb = '0;
  logic            flush = 1'b0;
  logic            busy, done;
  logic [XLEN-1:0] result;

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0] last_res = '0;

  ex_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] model(input logic [2:0] o, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    longint sa, sb_s, ub;
    logic [63:0] p;
    logic ovf;
    sa   = longint'($signed(a));
    sb_s = longint'($signed(b));
    ub   = longint'({32'd0, b});
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa * sb_s; return p[31:0]; end
      3'd1: begin p = sa * sb_s; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (ovf) return 32'h8000_0000;
        p = sa / sb_s; return p[31:0];
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return '0;
        p = sa % sb_s; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    if (o[2] && b == 0) return 1;
    if (o[2] && !o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return NORM_LAT;
  endfunction

  // Follows an accepted op cycle by cycle; start is held only in cycles [sfrom, sto]
  task automatic wait_done(input int sfrom, input int sto, output int lat, output int busy_err,
                           output logic [XLEN-1:0] res);
    lat = -1;
    busy_err = 0;
    res = '0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = (i >= sfrom) && (i <= sto);
      op    = 3'($urandom);
      srca  = $urandom;
      srcb  = $urandom;
      if (done === 1'b1) begin
        lat = i;
        res = result;
        if (busy !== 1'b0) busy_err++;
        break;
      end else if (busy !== 1'b1) begin
        busy_err++;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] er, input int el,
                        input int sfrom, input int sto);
    exp_t e;
    int lat, be;
    logic [XLEN-1:0] r;
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b; flush = 1'b0;
    sb.push_back('{er, el});
    wait_done(sfrom, sto, lat, be, r);
    e = sb.pop_front();
    checks++;
    if (r !== e.res) begin
      failures++;
      $display("FAIL %s result: got %h expected %h", name, r, e.res);
    end
    checks++;
    if (lat != e.lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
    end
    checks++;
    if (be != 0) begin
      failures++;
      $display("FAIL %s busy profile: got %0d bad cycles expected 0", name, be);
    end
    last_res = e.res;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      failures++;
      $display("FAIL reset outputs: got busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM_LAT, 0, 0);
    run_op("mulhu_max", 3'd3, '1, '1, 32'hFFFF_FFFE, NORM_LAT, 0, 0);
    run_op("mulh_m1", 3'd1, '1, '1, 32'h0, NORM_LAT, 0, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, '1, 32'h8000_0000, 1, 0, 0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, '1, 32'h0, 1, 0, 0);
    run_op("divu_by0", 3'd5, 32'd100, 32'd0, '1, 1, 0, 0);
    run_op("remu_by0", 3'd7, 32'd100, 32'd0, 32'd100, 1, 0, 0);
    run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORM_LAT, 0, 0);
    run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORM_LAT, 0, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NORM_LAT, 0, 0);
    run_op("div_by0_s", 3'd4, 32'hDEAD_BEEF, 32'd0, '1, 1, 0, 0);
    run_op("rem_by0_s", 3'd6, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1, 0, 0);
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [XLEN-1:0] a, b;
    for (int k = 0; k < 24; k++) begin
      o = 3'(k % 8);
      a = $urandom;
      b = (k % 5 == 4) ? 32'($urandom_range(0, 3)) : $urandom;
      if (k % 7 == 3) a = 32'(-($urandom_range(1, 50)));
      run_op("random", o, a, b, model(o, a, b), model_lat(o, a, b), 0, 0);
    end
  endtask

  task automatic test_ignore_busy();
    run_op("start_while_busy", 3'd5, 32'd1000, 32'd7, 32'd142, NORM_LAT, 3, 20);
  endtask

  task automatic test_flush();
    int seen = 0;
    logic [XLEN-1:0] prior;
    prior = last_res;
    @(negedge clk);
    start = 1'b1; op = 3'd4; srca = 32'd5000; srcb = 32'd3;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (i == 10);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush busy: got %b expected 0", busy);
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush done suppressed: got %0d pulses expected 0", seen);
    end
    checks++;
    if (result !== prior) begin
      failures++;
      $display("FAIL flush result held: got %h expected %h", result, prior);
    end
    // Restart in cycle 11, immediately after the flush took effect
    begin
      exp_t e;
      int lat, be;
      logic [XLEN-1:0] r;
      start = 1'b1; op = 3'd4; srca = 32'd5000; srcb = 32'd3;
      sb.push_back('{32'd1666, NORM_LAT});
      wait_done(0, 0, lat, be, r);
      e = sb.pop_front();
      checks++;
      if (r !== e.res || lat != e.lat) begin
        failures++;
        $display("FAIL flush restart: got %h lat %0d expected %h lat %0d", r, lat, e.res, e.lat);
      end
      last_res = e.res;
    end
  endtask

  task automatic test_flush_start();
    int seen = 0;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; srca = 32'd3; srcb = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_start busy: got %b expected 0", busy);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || result !== last_res) begin
      failures++;
      $display("FAIL flush_start dropped: got %0d pulses result %h expected 0 pulses result %h",
               seen, result, last_res);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat, be;
    logic [XLEN-1:0] r;
    run_op("b2b_first", 3'd0, 32'd12, 32'd11, 32'd132, NORM_LAT, 0, 0);
    start = 1'b1; op = 3'd7; srca = 32'd1003; srcb = 32'd10;
    sb.push_back('{32'd3, NORM_LAT});
    wait_done(0, 0, lat, be, r);
    e = sb.pop_front();
    checks++;
    if (lat != e.lat) begin
      failures++;
      $display("FAIL b2b latency: got %0d expected %0d", lat, e.lat);
    end
    checks++;
    if (r !== e.res) begin
      failures++;
      $display("FAIL b2b result: got %h expected %h", r, e.res);
    end
    last_res = e.res;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; op = 3'd1; srca = 32'h1234_5678; srcb = 32'h9ABC_DEF0;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      failures++;
      $display("FAIL reset_mid outputs: got busy=%b done=%b result=%h expected 0 0 0",
               busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, NORM_LAT, 0, 0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ignore_busy();
    test_flush();
    test_flush_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
